// File: rtl/loopback_pkg.sv
// loopback_pkg: mode encodings, counter width and the write-time byte transform
package loopback_pkg;
  localparam logic [1:0] MODE_ECHO   = 2'b00;
  localparam logic [1:0] MODE_CASE   = 2'b01;
  localparam logic [1:0] MODE_INVERT = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;
  localparam int CNT_W = 16;
  function automatic logic [7:0] xform(input logic [7:0] d, input logic [1:0] m);
    return m == MODE_CASE ?
             (((d >= 8'h41 && d <= 8'h5A) || (d >= 8'h61 && d <= 8'h7A)) ? d ^ 8'h20 : d) :
           m == MODE_INVERT ? ~d : d;
  endfunction
endpackage

// File: rtl/loopback_chan.sv
// loopback_chan: one loopback channel, FIFO with write-time transform and optional byte counter
module loopback_chan
  import loopback_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [7:0]       out_data_i,
  input  logic             out_valid_i,
  output logic             out_ready_o,
  output logic [7:0]       in_data_o,
  output logic             in_valid_o,
  input  logic             in_ready_i,
  input  logic [1:0]       mode_i,
  input  logic             flush_i,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] rx_count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          push, pop;
  assign empty_o     = occ == '0;
  assign full_o      = occ == (AW+1)'(DEPTH);
  assign out_ready_o = !full_o && !flush_i;
  assign in_valid_o  = !empty_o && !flush_i && mode_i != MODE_HOLD;
  assign in_data_o   = empty_o ? 8'h00 : mem[rd_ptr];
  assign push        = out_valid_i && out_ready_o;
  assign pop         = in_valid_o && in_ready_i;
  // pointer and occupancy bookkeeping; flush and reset both empty the channel
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // storage holds bytes already transformed with the mode of the accepting cycle
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= xform(out_data_i, mode_i);
  end
`ifdef LOOPBACK_STATS_EN
  logic [CNT_W-1:0] cnt;
  // saturating count of accepted bytes
  always_ff @(posedge clk_i) begin
    if (!rstn_i) cnt <= '0;
    else if (push && cnt != '1) cnt <= cnt + 1'b1;
  end
  assign rx_count_o = cnt;
`else
  assign rx_count_o = '0;
`endif
endmodule

// File: rtl/loopback_mch.sv
// loopback_mch: multi-channel byte loopback; LOOPBACK_STATS_EN enables per-channel rx byte counters
module loopback_mch
  import loopback_pkg::*;
#(
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 64
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [8*CHANNELS-1:0]     out_data_i,
  input  logic [CHANNELS-1:0]       out_valid_i,
  output logic [CHANNELS-1:0]       out_ready_o,
  output logic [8*CHANNELS-1:0]     in_data_o,
  output logic [CHANNELS-1:0]       in_valid_o,
  input  logic [CHANNELS-1:0]       in_ready_i,
  input  logic [2*CHANNELS-1:0]     mode_i,
  input  logic [CHANNELS-1:0]       flush_i,
  output logic [CHANNELS-1:0]       empty_o,
  output logic [CHANNELS-1:0]       full_o,
  output logic [CNT_W*CHANNELS-1:0] rx_count_o
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    loopback_chan #(.DEPTH(DEPTH)) u_chan (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .out_data_i (out_data_i[8*c +: 8]),
      .out_valid_i(out_valid_i[c]),
      .out_ready_o(out_ready_o[c]),
      .in_data_o  (in_data_o[8*c +: 8]),
      .in_valid_o (in_valid_o[c]),
      .in_ready_i (in_ready_i[c]),
      .mode_i     (mode_i[2*c +: 2]),
      .flush_i    (flush_i[c]),
      .empty_o    (empty_o[c]),
      .full_o     (full_o[c]),
      .rx_count_o (rx_count_o[CNT_W*c +: CNT_W])
    );
  end
endmodule

// File: tb/tb_loopback_mch.sv
// tb_loopback_mch: directed self-checking bench for a two-channel, depth-8 loopback
module tb_loopback_mch;
  localparam int CH = 2, DEPTH = 8;
`ifdef LOOPBACK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic        clk = 1'b0, rstn;
  logic [15:0] out_data, in_data;
  logic [1:0]  out_valid, out_ready, in_valid, in_ready, flush, empty, full;
  logic [3:0]  mode;
  logic [31:0] rx_count;
  int total = 0, bad = 0;
  logic [7:0] c1_in [3], c1_exp [3], c0_in [3];

  loopback_mch #(.CHANNELS(CH), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rstn_i(rstn), .out_data_i(out_data), .out_valid_i(out_valid),
    .out_ready_o(out_ready), .in_data_o(in_data), .in_valid_o(in_valid),
    .in_ready_i(in_ready), .mode_i(mode), .flush_i(flush), .empty_o(empty),
    .full_o(full), .rx_count_o(rx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(out_ready), 32'h3);
    chk({tag, "_valid"}, 32'(in_valid), 32'h0);
    chk({tag, "_empty"}, 32'(empty), 32'h3);
    chk({tag, "_full"}, 32'(full), 32'h0);
    chk({tag, "_count"}, rx_count, 32'h0);
    chk({tag, "_data"}, 32'(in_data), 32'h0);
  endtask

  initial begin
    c1_in  = '{8'h61, 8'h5A, 8'h35};
    c1_exp = '{8'h41, 8'h7A, 8'h35};
    c0_in  = '{8'h10, 8'h20, 8'h30};
    rstn = 1'b0; out_data = '0; out_valid = '0; in_ready = '0; mode = '0; flush = '0;
    tick(); tick();
    chk_reset("rst");
    rstn = 1'b1;
    tick();
    // echo on ch0: 0x01..0x07, one-cycle latency
    for (int i = 0; i < 7; i++) begin
      out_valid[0] = 1'b1; out_data[7:0] = 8'(i + 1); #1;
      chk("echo_ready", 32'(out_ready[0]), 32'h1);
      if (i == 0) chk("echo_nolat", 32'(in_valid[0]), 32'h0);
      tick();
      if (i == 0) begin
        chk("echo_lat_v", 32'(in_valid[0]), 32'h1);
        chk("echo_lat_d", 32'(in_data[7:0]), 32'h1);
      end
    end
    out_valid = '0; in_ready[0] = 1'b1; #1;
    for (int i = 0; i < 7; i++) begin
      chk("echo_rd_v", 32'(in_valid[0]), 32'h1);
      chk("echo_rd_d", 32'(in_data[7:0]), 32'(i + 1));
      tick();
    end
    in_ready = '0; #1;
    chk("echo_empty", 32'(empty[0]), 32'h1);
    chk("cnt0_a", 32'(rx_count[15:0]), STATS ? 32'd7 : 32'd0);
    // case on ch1 concurrent with echo on ch0; mode change after write keeps stored bytes
    mode = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      out_valid = 2'b11; out_data = {c1_in[i], c0_in[i]};
      tick();
    end
    out_valid = '0; mode = '0; in_ready = 2'b11; #1;
    for (int i = 0; i < 3; i++) begin
      chk("case_v", 32'(in_valid), 32'h3);
      chk("case_d1", 32'(in_data[15:8]), 32'(c1_exp[i]));
      chk("case_d0", 32'(in_data[7:0]), 32'(c0_in[i]));
      tick();
    end
    in_ready = '0;
    // invert on ch0
    mode[1:0] = 2'b10; out_valid[0] = 1'b1; out_data[7:0] = 8'h3C;
    tick();
    out_valid = '0; mode = '0; #1;
    chk("inv_d", 32'(in_data[7:0]), 32'hC3);
    in_ready[0] = 1'b1;
    tick();
    in_ready = '0;
    chk("cnt0_b", 32'(rx_count[15:0]), STATS ? 32'd11 : 32'd0);
    chk("cnt1_b", 32'(rx_count[31:16]), STATS ? 32'd3 : 32'd0);
    // hold on ch0 fills to full, ninth byte held upstream
    mode[1:0] = 2'b11; in_ready[0] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      out_valid[0] = 1'b1; out_data[7:0] = 8'(8'h80 + i); #1;
      chk("hold_ready", 32'(out_ready[0]), 32'(i < 8));
      chk("hold_v", 32'(in_valid[0]), 32'h0);
      if (i < 8) tick();
    end
    chk("hold_full", 32'(full[0]), 32'h1);
    mode[1:0] = 2'b00;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk("rel_v", 32'(in_valid[0]), 32'h1);
      chk("rel_d", 32'(in_data[7:0]), 32'(8'h80 + k));
      if (k == 0) chk("rel_ready0", 32'(out_ready[0]), 32'h0);
      if (k == 1) begin
        chk("rel_ready1", 32'(out_ready[0]), 32'h1);
        chk("rel_full1", 32'(full[0]), 32'h0);
      end
      tick();
      if (k == 1) out_valid[0] = 1'b0;
    end
    in_ready = '0; #1;
    chk("rel_empty", 32'(empty[0]), 32'h1);
    chk("cnt0_c", 32'(rx_count[15:0]), STATS ? 32'd20 : 32'd0);
    // flush on ch1 with a byte offered in the same cycle
    for (int i = 0; i < 5; i++) begin
      out_valid[1] = 1'b1; out_data[15:8] = 8'(8'hA0 + i);
      tick();
    end
    flush[1] = 1'b1; out_data[15:8] = 8'hEE; #1;
    chk("fl_ready", 32'(out_ready[1]), 32'h0);
    chk("fl_v", 32'(in_valid[1]), 32'h0);
    tick();
    flush = '0; out_valid = '0; #1;
    chk("fl_empty", 32'(empty[1]), 32'h1);
    chk("fl_v2", 32'(in_valid[1]), 32'h0);
    chk("fl_d", 32'(in_data[15:8]), 32'h0);
    chk("fl_cnt", 32'(rx_count[31:16]), STATS ? 32'd8 : 32'd0);
    out_valid[1] = 1'b1; out_data[15:8] = 8'h55;
    tick();
    out_valid = '0; #1;
    chk("fl_after_v", 32'(in_valid[1]), 32'h1);
    chk("fl_after_d", 32'(in_data[15:8]), 32'h55);
    in_ready[1] = 1'b1;
    tick();
    in_ready = '0; #1;
    chk("fl_after_empty", 32'(empty[1]), 32'h1);
    // reset mid-transfer
    out_valid[0] = 1'b1; out_data[7:0] = 8'h77;
    tick(); tick();
    chk("mid_v", 32'(in_valid[0]), 32'h1);
    rstn = 1'b0;
    tick();
    chk_reset("rst_mid");
    // long stream: counter saturation, then reset mid-stream
    rstn = 1'b1; out_valid = 2'b01; in_ready = 2'b01;
    repeat (70000) tick();
    chk("sat_cnt0", 32'(rx_count[15:0]), STATS ? 32'hFFFF : 32'h0);
    chk("sat_cnt1", 32'(rx_count[31:16]), 32'h0);
    chk("sat_v", 32'(in_valid[0]), 32'h1);
    rstn = 1'b0;
    tick();
    chk_reset("rst_stream");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/loopback_mch.md
LOOPBACK_MCH -- requirements
Module: loopback_mch

Interface
REQ-001 SHALL have parameter CHANNELS, default 1, number of independent byte-stream loopback channels (1..8).
REQ-002 SHALL have parameter DEPTH, default 64, per-channel FIFO depth in bytes (power of 2, 2..256).
REQ-003 SHALL have port clk_i  input  1  single clock for all logic.
REQ-004 SHALL have port rstn_i  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port out_data_i  input  8*CHANNELS  host-to-device bytes from the CDC core, channel c in bits [8c+7:8c].
REQ-006 SHALL have port out_valid_i  input  CHANNELS  per-channel byte valid.
REQ-007 SHALL have port out_ready_o  output  CHANNELS  per-channel byte accept.
REQ-008 SHALL have port in_data_o  output  8*CHANNELS  device-to-host bytes to the CDC core.
REQ-009 SHALL have port in_valid_o  output  CHANNELS  per-channel byte valid.
REQ-010 SHALL have port in_ready_i  input  CHANNELS  per-channel byte accept.
REQ-011 SHALL have port mode_i  input  2*CHANNELS  per-channel mode: 00 ECHO, 01 CASE (toggle ASCII letter case), 10 INVERT (bitwise NOT), 11 HOLD.
REQ-012 SHALL have port flush_i  input  CHANNELS  per-channel synchronous FIFO clear.
REQ-013 SHALL have ports empty_o and full_o  output  CHANNELS  per-channel FIFO status.
REQ-014 SHALL have port rx_count_o  output  16*CHANNELS  per-channel count of bytes accepted.

Function
REQ-015 Each channel SHALL be independent; no state or handshake is shared between channels.
REQ-016 Write handshake: byte accepted on a rising clk_i when out_valid_i & out_ready_o; out_ready_o = !full & !flush_i.
REQ-017 Read handshake: byte removed when in_valid_o & in_ready_i; in_valid_o = !empty & !flush_i & (mode != HOLD).
REQ-018 The transform SHALL be applied at write time using mode_i of the accepting cycle; later mode changes never alter stored bytes.
REQ-019 CASE: bytes 0x41..0x5A and 0x61..0x7A SHALL be XORed with 0x20; all other bytes pass unchanged; HOLD stores bytes unchanged.
REQ-020 Latency: a byte accepted into an empty FIFO in cycle N SHALL present on in_data_o with in_valid_o=1 in cycle N+1.
REQ-021 in_data_o SHALL equal the FIFO head whenever in_valid_o=1 and SHALL stay stable until the read handshake.
REQ-022 Occupancy SHALL use log2(DEPTH)+1 bits; pointers SHALL wrap modulo DEPTH without loss.
REQ-023 Full: out_ready_o=0 and the byte is held upstream; simultaneous pop makes out_ready_o=1 the next cycle.
REQ-024 Empty: in_valid_o=0; a push in the same cycle is not readable until the next cycle.
REQ-025 Push and pop in the same cycle at partial occupancy SHALL leave occupancy unchanged.
REQ-026 flush_i=1 SHALL empty the channel at the clock edge; both handshakes are suppressed that cycle; rx_count_o is unaffected.
REQ-027 HOLD SHALL keep accepting bytes until full; leaving HOLD releases them in order.

Reset
REQ-028 rstn_i=0 at a rising edge SHALL empty all FIFOs and clear rx_count_o, including mid-transfer; the FIFO storage array is not reset.
REQ-029 During and after reset: out_ready_o=all 1, in_valid_o=0, empty_o=all 1, full_o=0, rx_count_o=0, in_data_o=0.

Configuration
REQ-030 With LOOPBACK_STATS_EN defined, rx_count_o SHALL increment once per accepted byte and saturate at 0xFFFF.
REQ-031 Without LOOPBACK_STATS_EN, rx_count_o SHALL be constant 0 and no counter registers are synthesised.

Structure
REQ-032 Package loopback_pkg SHALL hold the mode encodings (ECHO, CASE, INVERT, HOLD) and the 16-bit counter width constant.
REQ-033 The single-channel FIFO with transform and counter SHALL be sub-module loopback_chan, instantiated CHANNELS times by a generate loop.

Verification
REQ-034 CHANNELS=2, mode 00 on ch0: send 0x01..0x07 and read back -> 0x01..0x07 in order, first in_valid_o one cycle after first accept.
REQ-035 Mode 01 on ch1: send "aZ5" (0x61 0x5A 0x35) -> read 0x41 0x7A 0x35; ch0 traffic concurrently unaffected.
REQ-036 DEPTH=8, mode 11: push 9 bytes -> 8 accepted, out_ready_o=0 on the 9th, full_o=1; switch to 00 -> 8 bytes out, then the 9th.
REQ-037 Fill 5 bytes, assert flush_i one cycle with out_valid_i=1 -> empty_o=1, in_valid_o=0, pushed byte not stored.
REQ-038 With LOOPBACK_STATS_EN: 70000 accepted bytes -> rx_count_o=0xFFFF; assert rstn_i=0 mid-stream -> all outputs at REQ-029 values next cycle.
